// File: rtl/adder_pkg.sv
// Shared definitions for the adder tree and its input gatherer: default geometry,
// the packed lane-array type and the lane-count width helper.
package adder_pkg;

    localparam int ADDER_BITS = 8;
    localparam int ADDER_NUM  = 8;

    typedef logic [ADDER_NUM-1:0][ADDER_BITS-1:0] lanes_t;

    // Width able to hold every count 0..num (num itself is a legal lane count).
    function automatic int lane_count_w(input int num);
        return $clog2(num + 1);
    endfunction

endpackage

// File: rtl/adder_gather.sv
// Gathers a serial valid/ready word stream into NUM parallel lanes for the adder tree,
// with early close (zero-padded), abort of a partial set and a one-cycle set pulse.
module adder_gather
    import adder_pkg::*;
#(
    parameter int BITS = ADDER_BITS,
    parameter int NUM  = ADDER_NUM
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BITS-1:0]               in_data,
    input  logic                          in_last,
    input  logic                          abort,
    output logic [BITS-1:0]               data_out__0,
    output logic [BITS-1:0]               data_out__1,
    output logic [BITS-1:0]               data_out__2,
    output logic [BITS-1:0]               data_out__3,
    output logic [BITS-1:0]               data_out__4,
    output logic [BITS-1:0]               data_out__5,
    output logic [BITS-1:0]               data_out__6,
    output logic [BITS-1:0]               data_out__7,
    output logic                          valid_out,
    output logic [lane_count_w(NUM)-1:0]  lanes_used,
    output logic                          state_dbg
);

    localparam int IW = $clog2(NUM);
    localparam int LW = lane_count_w(NUM);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    // Handshake: a word transfers when in_valid & in_ready; in_ready only drops during abort.
    logic                      xfer;
    logic                      close;
    logic [IW-1:0]             idx;
    logic [NUM-1:0][BITS-1:0]  shadow;
    logic [NUM-1:0][BITS-1:0]  lanes_next;
    logic [NUM-1:0][BITS-1:0]  out_lanes;

    assign in_ready  = ~abort;
    assign xfer      = in_valid & in_ready;
    assign close     = xfer & ((idx == IW'(NUM - 1)) | in_last);
    assign state_dbg = (idx == '0) ? ST_IDLE : ST_FILL;

    // Lanes above idx are already zero because shadow is cleared at every close/abort.
    always_comb begin
        lanes_next      = shadow;
        lanes_next[idx] = in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            shadow     <= '0;
            out_lanes  <= '0;
            valid_out  <= 1'b0;
            lanes_used <= '0;
        end else if (abort) begin
            idx       <= '0;
            shadow    <= '0;
            valid_out <= 1'b0;
        end else if (close) begin
            idx        <= '0;
            shadow     <= '0;
            out_lanes  <= lanes_next;
            valid_out  <= 1'b1;
            lanes_used <= {{(LW-IW){1'b0}}, idx} + LW'(1);
        end else if (xfer) begin
            idx       <= idx + IW'(1);
            shadow    <= lanes_next;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
        end
    end

    // The per-lane port list is written out for the default eight-lane adder.
    assign data_out__0 = out_lanes[0];
    assign data_out__1 = out_lanes[1];
    assign data_out__2 = out_lanes[2];
    assign data_out__3 = out_lanes[3];
    assign data_out__4 = out_lanes[4];
    assign data_out__5 = out_lanes[5];
    assign data_out__6 = out_lanes[6];
    assign data_out__7 = out_lanes[7];

endmodule

// File: tb/tb_adder_gather.sv
// Self-checking bench for adder_gather: directed vector table, hand sequences and
// randomized traffic scored against a queue-based model of set collection.
module tb_adder_gather;

    localparam int BITS = 8;
    localparam int NUM  = 8;
    localparam int LW   = 4;
    localparam int W    = LW + NUM * BITS;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [BITS-1:0]   in_data;
    logic              in_last;
    logic              abort;
    logic [BITS-1:0]   dout [NUM];
    logic              valid_out;
    logic [LW-1:0]     lanes_used;
    logic              state_dbg;
    logic [NUM*BITS-1:0] lanes_flat;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]    exp_q[$];
    logic [BITS-1:0] cur_q[$];

    adder_gather #(.BITS(BITS), .NUM(NUM)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .abort(abort),
        .data_out__0(dout[0]), .data_out__1(dout[1]), .data_out__2(dout[2]),
        .data_out__3(dout[3]), .data_out__4(dout[4]), .data_out__5(dout[5]),
        .data_out__6(dout[6]), .data_out__7(dout[7]),
        .valid_out(valid_out), .lanes_used(lanes_used), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always_comb begin
        lanes_flat = '0;
        for (int k = 0; k < NUM; k++) lanes_flat[k*BITS +: BITS] = dout[k];
    end

    // Reference: accepted words accumulate in a list; a full list or in_last yields a set.
    task automatic model_step(input logic r, input logic v, input logic [BITS-1:0] d,
                              input logic l, input logic ab);
        logic [NUM*BITS-1:0] set;
        int n;
        if (r || ab) begin
            cur_q.delete();
        end else if (v) begin
            cur_q.push_back(d);
            if (cur_q.size() == NUM || l) begin
                set = '0;
                n = cur_q.size();
                for (int k = 0; k < n; k++) set[k*BITS +: BITS] = cur_q[k];
                exp_q.push_back({LW'(n), set});
                cur_q.delete();
            end
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic [BITS-1:0] d,
                         input logic l, input logic ab);
        rst = r; in_valid = v; in_data = d; in_last = l; abort = ab;
        #1;
        checks++;
        if (in_ready !== ~ab) begin
            errors++;
            $display("FAIL in_ready: got %b want %b", in_ready, ~ab);
        end
        @(posedge clk);
        model_step(r, v, d, l, ab);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Scoreboard: a pulse is due exactly one cycle after each modelled close, never otherwise.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checks++;
            if (valid_out !== 1'b1) begin
                errors++;
                $display("FAIL pulse_missing: valid_out=%b want 1 (set %h)", valid_out, exp_q[0]);
            end else if ({lanes_used, lanes_flat} !== exp_q[0]) begin
                errors++;
                $display("FAIL set_data: got used=%0d lanes=%h want used=%0d lanes=%h",
                         lanes_used, lanes_flat, exp_q[0][W-1 -: LW], exp_q[0][NUM*BITS-1:0]);
            end
            void'(exp_q.pop_front());
        end else begin
            checks++;
            if (valid_out !== 1'b0) begin
                errors++;
                $display("FAIL spurious_pulse: valid_out=%b lanes=%h used=%0d",
                         valid_out, lanes_flat, lanes_used);
            end
        end
    end

    typedef struct {
        logic            v;
        logic [BITS-1:0] d;
        logic            l;
        logic            ab;
        logic            exp_vout;
        logic [LW-1:0]   exp_used;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic v, input logic [BITS-1:0] d, input logic l,
                           input logic ab, input logic ev, input logic [LW-1:0] eu);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.ab = ab; t.exp_vout = ev; t.exp_used = eu;
        vecs.push_back(t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BITS-1:0] sum;
        int pulses;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; abort = 1'b0;
        @(posedge clk); #1;

        // 1: reset held three cycles with in_valid high
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        checks++;
        if (valid_out !== 1'b0 || lanes_flat !== '0 || lanes_used !== '0 || in_ready !== 1'b1
            || state_dbg !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: vout=%b lanes=%h used=%0d ready=%b state=%b",
                     valid_out, lanes_flat, lanes_used, in_ready, state_dbg);
        end
        idle(3);

        // 2: 16 back-to-back words; pulses after word 8 and word 16
        pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
            if (valid_out === 1'b1) pulses++;
            checks++;
            if (valid_out !== ((i == 8) || (i == 16))) begin
                errors++;
                $display("FAIL b2b_timing: word %0d valid_out=%b", i, valid_out);
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d pulses want 2", pulses);
        end
        checks++;
        if (lanes_flat !== 64'h100f0e0d0c0b0a09) begin
            errors++;
            $display("FAIL b2b_second_set: got %h want 100f0e0d0c0b0a09", lanes_flat);
        end
        idle(2);

        // 3: gapped input, random idle cycles between words
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
            if (i != 7) idle($urandom_range(0, 3));
        end
        checks++;
        if (valid_out !== 1'b1 || lanes_flat !== 64'h1817161514131211) begin
            errors++;
            $display("FAIL gapped_set: vout=%b lanes=%h want 1/1817161514131211",
                     valid_out, lanes_flat);
        end
        idle(2);

        // 4 + 5: table of early close, abort and recovery
        add_vec(1, 8'h0a, 0, 0, 0, 0);
        add_vec(1, 8'h0b, 0, 0, 0, 0);
        add_vec(1, 8'h0c, 1, 0, 1, 3);
        for (int i = 0; i < 8; i++) add_vec(1, 8'(8'h40 + i), 0, 0, i == 7, 8);
        for (int i = 0; i < 5; i++) add_vec(1, 8'(8'h50 + i), 0, 0, 0, 0);
        add_vec(1, 8'h5f, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) add_vec(1, 8'(8'h10 + i), 0, 0, i == 7, 8);
        add_vec(1, 8'h77, 1, 0, 1, 1);
        add_vec(1, 8'h78, 1, 0, 1, 1);
        add_vec(0, 8'h00, 0, 1, 0, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(1'b0, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].ab);
            checks++;
            if (valid_out !== vecs[i].exp_vout ||
                (vecs[i].exp_vout && lanes_used !== vecs[i].exp_used)) begin
                errors++;
                $display("FAIL vec[%0d]: vout=%b used=%0d want vout=%b used=%0d",
                         i, valid_out, lanes_used, vecs[i].exp_vout, vecs[i].exp_used);
            end
        end
        idle(2);

        // 6: reset mid-fill, then a full set whose lane sum wraps mod 2^BITS
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        sum = '0;
        for (int k = 0; k < NUM; k++) sum = sum + dout[k];
        checks++;
        if (valid_out !== 1'b1 || sum !== 8'h1c) begin
            errors++;
            $display("FAIL reset_midfill_sum: vout=%b sum=%h want 1/1c", valid_out, sum);
        end
        idle(2);

        // Randomized traffic with gaps, early closes, aborts and rare resets
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0,
                  8'($urandom_range(0, 255)), $urandom_range(0, 6) == 0,
                  $urandom_range(0, 20) == 0);
        end
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected sets never presented", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
